// File: rtl/nfc_pkg.sv
// Shared types and constants for the NAND read-path error injector.
package nfc_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, STREAM = 2'd2, DONE = 2'd3} state_t;

  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  localparam int          PAGE_BEATS_DEF = 2112;
endpackage

// File: rtl/nfc_lfsr.sv
// Right-shifting Galois LFSR; picks one error position per segment.
module nfc_lfsr import nfc_pkg::*; #(
  parameter int LFSR_W = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);
  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(LFSR_TAPS);

  // An all-zero state would lock up, so a zero seed is treated as one.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)  q <= LFSR_W'(1);
    else if (load) q <= (seed == '0) ? LFSR_W'(1) : seed;
    else if (step) q <= (q >> 1) ^ (q[0] ? TAPS : '0);
  end
endmodule

// File: rtl/nand_err_inject.sv
// Streams one NAND page through a single register stage, flipping one bit
// per 2^k-beat segment at an LFSR-chosen offset and bit.
module nand_err_inject import nfc_pkg::*; #(
  parameter int DATA_W       = 8,
  parameter int PAGE_BEATS   = PAGE_BEATS_DEF,
  parameter int SEG_LOG2_MAX = 11,
  parameter int LFSR_W       = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cfg_en,
  input  logic [3:0]        cfg_seg_log2,
  input  logic [LFSR_W-1:0] cfg_seed,
  input  logic              page_start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              page_done,
  output logic [15:0]       err_cnt
);
  localparam int BEAT_W = $clog2(PAGE_BEATS + 1);
  localparam int BIT_W  = $clog2(DATA_W);

  state_t            state;
  logic              cfg_en_q;
  logic [3:0]        seg_log2_q;
  logic [LFSR_W-1:0] seed_q;
  logic [BEAT_W-1:0] beat_cnt;
  logic [LFSR_W-1:0] lfsr, seg_mask, seg_idx, tgt_off;
  logic [BIT_W-1:0]  tgt_bit;
  logic [DATA_W-1:0] flip;
  logic              accept, hit, seg_end, last_beat, lfsr_load;

  assign s_ready   = (state == STREAM) && (!m_valid || m_ready);
  assign accept    = s_valid && s_ready;
  assign lfsr_load = (state == ARM);

  // Pages start at beat 0, so the in-segment index is just the low k bits.
  assign seg_mask  = (LFSR_W'(1) << seg_log2_q) - LFSR_W'(1);
  assign seg_idx   = LFSR_W'(beat_cnt) & seg_mask;
  assign tgt_off   = lfsr & seg_mask;
  assign tgt_bit   = BIT_W'(lfsr >> seg_log2_q);
  assign hit       = cfg_en_q && (seg_idx == tgt_off);
  assign flip      = hit ? (DATA_W'(1) << tgt_bit) : '0;
  assign seg_end   = accept && (seg_idx == seg_mask);
  assign last_beat = (beat_cnt == BEAT_W'(PAGE_BEATS - 1));

  nfc_lfsr #(.LFSR_W(LFSR_W)) u_lfsr (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .load    (lfsr_load),
    .seed    (seed_q),
    .step    (seg_end),
    .q       (lfsr)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= IDLE;
      cfg_en_q   <= 1'b0;
      seg_log2_q <= '0;
      seed_q     <= '0;
      beat_cnt   <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      page_done  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      page_done <= 1'b0;

      if (accept) begin
        m_valid <= 1'b1;
        m_data  <= s_data ^ flip;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      // page_start outside ARM restarts; the output register drains on its own.
      if (page_start && state != ARM) begin
        cfg_en_q   <= cfg_en;
        seg_log2_q <= (cfg_seg_log2 > 4'(SEG_LOG2_MAX)) ? 4'(SEG_LOG2_MAX) : cfg_seg_log2;
        seed_q     <= cfg_seed;
        state      <= ARM;
      end else begin
        case (state)
          ARM: begin
            beat_cnt <= '0;
            err_cnt  <= '0;
            state    <= STREAM;
          end
          STREAM: if (accept) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
            if (hit && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            if (last_beat) state <= DONE;
          end
          DONE: if (m_valid && m_ready) begin
            page_done <= 1'b1;
            state     <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_nand_err_inject.sv
// Randomized page-level bench against a behavioural flip-position model.
module tb_nand_err_inject;
  localparam int PAGE = 2112;

  logic        HCLK = 1'b0, HRESETn = 1'b0;
  logic        cfg_en = 1'b0, page_start = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic [3:0]  cfg_seg_log2 = '0;
  logic [15:0] cfg_seed = '0;
  logic [7:0]  s_data = '0;
  logic        s_ready, m_valid, page_done;
  logic [7:0]  m_data;
  logic [15:0] err_cnt;

  int n_cmp = 0, n_bad = 0;
  logic [7:0] din   [PAGE];
  logic [7:0] dflip [PAGE];

  nand_err_inject #(.DATA_W(8), .PAGE_BEATS(PAGE), .SEG_LOG2_MAX(11), .LFSR_W(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .cfg_en(cfg_en), .cfg_seg_log2(cfg_seg_log2),
    .cfg_seed(cfg_seed), .page_start(page_start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .page_done(page_done), .err_cnt(err_cnt)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Galois step written arithmetically: halve, then xor taps if the LSB was 1.
  function automatic int lfsr_next(input int v);
    return (v / 2) ^ ((v % 2) != 0 ? 'hB400 : 0);
  endfunction

  task automatic build_model(input bit en, input int k, input logic [15:0] seed, input bit inc);
    int l, len, off, b;
    l   = (seed == 16'h0) ? 1 : int'(seed);
    len = 1 << k;
    for (int i = 0; i < PAGE; i++) begin
      din[i]   = inc ? 8'(i) : 8'($urandom);
      dflip[i] = 8'h00;
    end
    for (int base = 0; base < PAGE; base += len) begin
      off = l % len;
      b   = (l / len) % 8;
      if (en && base + off < PAGE) dflip[base + off] = 8'(1 << b);
      l = lfsr_next(l);
    end
  endtask

  task automatic run_page(input bit en, input int k, input logic [15:0] seed, input bit inc,
                          input int vld_pct, input int rdy_pct, input int nsend,
                          input bit rst_mid, input bit from_idle, input bit chk_time);
    int sent = 0, rcv = 0, cyc = 0, first = -1, first_out = -1;
    int done_cnt = 0, done_cyc = -1, exp_err = 0;
    bit held_v = 0, was_rst = 0;
    logic [7:0] held_d = '0;
    build_model(en, k, seed, inc);
    for (int i = 0; i < nsend; i++) if (dflip[i] != 8'h00) exp_err++;

    @(negedge HCLK);
    cfg_en = en; cfg_seg_log2 = 4'(k); cfg_seed = seed;
    page_start = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
    #1;
    if (from_idle) chk("rdy_idle", {31'b0, s_ready}, 0);
    // ARM cycle: offer a beat and scramble cfg; neither may take effect.
    @(negedge HCLK);
    page_start = 1'b0; s_valid = 1'b1; s_data = 8'hA5;
    cfg_en = ~en; cfg_seed = ~seed; cfg_seg_log2 = ~cfg_seg_log2;
    #1;
    chk("rdy_arm", {31'b0, s_ready}, 0);

    while (!was_rst && rcv < nsend && cyc < 20000) begin
      @(negedge HCLK);
      s_valid = (sent < nsend) && ($urandom_range(99) < vld_pct);
      s_data  = din[(sent < PAGE) ? sent : 0];
      m_ready = ($urandom_range(99) < rdy_pct);
      #1;
      if (cyc == 0) chk("err_clr", {16'b0, err_cnt}, 0);
      if (rst_mid && sent == nsend) begin
        HRESETn = 1'b0;
        #1;
        chk("rst_mval", {31'b0, m_valid}, 0);
        chk("rst_mdat", {24'b0, m_data}, 0);
        chk("rst_srdy", {31'b0, s_ready}, 0);
        chk("rst_done", {31'b0, page_done}, 0);
        chk("rst_err",  {16'b0, err_cnt}, 0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        was_rst = 1;
      end else begin
        if (held_v) begin
          chk("stall_v", {31'b0, m_valid}, 1);
          chk("stall_d", {24'b0, m_data}, {24'b0, held_d});
        end
        held_v = m_valid && !m_ready;
        held_d = m_data;
        if (m_valid && m_ready) begin
          chk("data", {24'b0, m_data}, {24'b0, din[rcv] ^ dflip[rcv]});
          if (first_out < 0) first_out = cyc;
          rcv++;
        end
        if (page_done) begin done_cnt++; done_cyc = cyc; end
        if (s_valid && s_ready) begin
          if (first < 0) first = cyc;
          sent++;
        end
        cyc++;
      end
    end
    if (!was_rst) chk("drained", rcv, nsend);

    s_valid = 1'b0;
    repeat (3) begin
      @(negedge HCLK);
      m_ready = 1'b1;
      #1;
      if (page_done) begin done_cnt++; done_cyc = cyc; end
      cyc++;
    end
    chk("done_cnt", done_cnt, (nsend == PAGE && !rst_mid) ? 1 : 0);
    if (!was_rst) chk("err_cnt", {16'b0, err_cnt}, exp_err);
    if (chk_time) begin
      chk("latency", first_out - first, 1);
      chk("done_time", done_cyc - first, PAGE + 1);
    end
  endtask

  initial begin
    #2;
    chk("rst0_mval", {31'b0, m_valid}, 0);
    chk("rst0_mdat", {24'b0, m_data}, 0);
    chk("rst0_srdy", {31'b0, s_ready}, 0);
    chk("rst0_done", {31'b0, page_done}, 0);
    chk("rst0_err",  {16'b0, err_cnt}, 0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;

    run_page(0, 6,  16'h1234, 1, 100, 100, PAGE, 0, 1, 1);
    run_page(1, 6,  16'hACE1, 0, 100, 100, PAGE, 0, 1, 1);
    run_page(1, 11, 16'($urandom), 0, 100, 100, PAGE, 0, 1, 1);
    run_page(1, int'($urandom_range(11)), 16'($urandom), 0, 80, 50, PAGE, 0, 1, 0);
    run_page(1, 0,  16'($urandom), 0, 90, 70, PAGE, 0, 1, 0);
    run_page(1, 4,  16'h0000, 0, 90, 100, 500, 0, 1, 0);
    run_page(1, 4,  16'h0000, 0, 90, 60, PAGE, 0, 0, 0);
    run_page(1, 5,  16'($urandom), 0, 90, 60, 1000, 1, 1, 0);
    run_page(1, 7,  16'($urandom), 0, 80, 50, PAGE, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/nand_err_inject.md
NAND_ERR_INJECT -- requirements
Module: nand_err_inject

Interface
REQ-001 Parameter DATA_W, default 8, width of the NAND data bus beat.
REQ-002 Parameter PAGE_BEATS, default 2112, beats per page (2048 data + 64 spare).
REQ-003 Parameter SEG_LOG2_MAX, default 11, largest allowed segment size exponent.
REQ-004 Parameter LFSR_W, default 16, width of the position generator.
REQ-005 HCLK  in  1  sole clock; HRESETn  in  1  asynchronous, active-low reset.
REQ-006 cfg_en  in  1  enables injection; when 0 data passes unmodified.
REQ-007 cfg_seg_log2  in  4  segment size is 2^cfg_seg_log2 beats, 0..SEG_LOG2_MAX.
REQ-008 cfg_seed  in  LFSR_W  LFSR seed for the page.
REQ-009 page_start  in  1  single-cycle pulse that begins a page.
REQ-010 s_valid in 1, s_data in DATA_W, s_ready out 1  upstream beat handshake (flash read data).
REQ-011 m_valid out 1, m_data out DATA_W, m_ready in 1  downstream beat handshake (toward controller).
REQ-012 page_done  out 1  one-cycle pulse at page completion; err_cnt  out 16  bit flips injected this page.

Function
REQ-013 The block SHALL use states IDLE, ARM, STREAM, DONE.
REQ-014 IDLE: page_start -> ARM; cfg_* sampled into internal registers on that cycle.
REQ-015 ARM (1 cycle): LFSR loaded with cfg_seed (0 replaced by 1); beat and segment counters cleared; err_cnt cleared; -> STREAM.
REQ-016 The LFSR SHALL be Galois, taps 0xB400 for LFSR_W=16, advancing once at every segment boundary.
REQ-017 Per segment: target offset = LFSR[k-1:0], target bit = LFSR[k+log2(DATA_W)-1:k], with k = cfg_seg_log2.
REQ-018 The accepted beat whose in-segment index equals the target offset SHALL have its target bit inverted when cfg_en=1; err_cnt increments, saturating at 0xFFFF.
REQ-019 In a final partial segment, a target offset beyond the last beat SHALL inject nothing.
REQ-020 Datapath: one register stage; s_ready = in STREAM and (!m_valid or m_ready); latency 1 cycle from acceptance to m_valid.
REQ-021 m_data/m_valid SHALL hold stable while m_valid=1 and m_ready=0.
REQ-022 After PAGE_BEATS beats are accepted -> DONE; s_ready=0.
REQ-023 DONE: page_done pulses on the cycle the last beat is consumed downstream (m_valid & m_ready); next state IDLE.
REQ-024 page_start in STREAM or DONE SHALL abort the page and go to ARM; any beat already in the output register completes normally; page_done is not pulsed.
REQ-025 s_ready SHALL be 0 in IDLE and ARM; beats offered then are not accepted.

Reset
REQ-026 HRESETn low SHALL asynchronously force IDLE, m_valid=0, m_data=0, s_ready=0, page_done=0, err_cnt=0, LFSR=1, all counters 0.
REQ-027 Reset mid-page SHALL drop the in-flight beat; no page_done is issued.

Structure
REQ-028 State enum, the LFSR tap constant and the PAGE_BEATS default SHALL reside in shared package nfc_pkg.
REQ-029 The LFSR SHALL be a sub-module nfc_lfsr (parameter LFSR_W, ports load, seed, step, q).

Verification
REQ-030 cfg_en=0, 2112 incrementing beats, m_ready=1 -> output equals input, err_cnt=0, page_done once, 2112 cycles after the first acceptance plus 1.
REQ-031 cfg_en=1, seg_log2=6, seed=0xACE1 -> exactly 33 single-bit flips, one per 64-beat segment, at reference-model positions, err_cnt=33.
REQ-032 seg_log2=11 -> segment 2 is 64 beats; err_cnt is 1 or 2 per the model, never 0 for segment 1.
REQ-033 Random m_ready backpressure 50% -> no beat lost or duplicated; m_data stable while stalled.
REQ-034 page_start at beat 500 -> restart, err_cnt cleared, no page_done for aborted page; seed=0 behaves as seed=1.
REQ-035 HRESETn low at beat 1000 -> all outputs return to reset values asynchronously; next page runs correctly.
